// File: rtl/victim_buffer_ctrl_pkg.sv
// rtl/victim_buffer_ctrl_pkg.sv - shared types and constants for the victim buffer controller
// Holds the FSM state enum, slot count and the slot-entry struct.
package victim_buffer_ctrl_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int TAG_W     = 26;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_WB,
    ST_SETTLE
  } vb_state_e;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } vb_slot_t;

endpackage

// File: rtl/victim_buffer_ctrl_tag_match.sv
// rtl/victim_buffer_ctrl_tag_match.sv - victim_tag_match: parallel tag compare over all slots
// Returns a one-hot hit vector (valid slots only) and a one-hot lowest-index invalid slot.
module victim_tag_match
  import victim_buffer_ctrl_pkg::*;
(
  input  logic [TAG_W-1:0]               tag_i,
  input  vb_slot_t [NUM_SLOTS-1:0]       slots_i,
  output logic [NUM_SLOTS-1:0]           hit_o,
  output logic [NUM_SLOTS-1:0]           free_o
);

  logic seen_free;
  logic unused_bits;

  always_comb begin
    hit_o       = '0;
    free_o      = '0;
    seen_free   = 1'b0;
    unused_bits = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_o[i] = slots_i[i].valid && (slots_i[i].tag == tag_i);
      if (!slots_i[i].valid && !seen_free) begin
        free_o[i] = 1'b1;
        seen_free = 1'b1;
      end
      unused_bits = unused_bits ^ (^{slots_i[i].dirty, slots_i[i].data});
    end
  end

endmodule

// File: rtl/victim_buffer_ctrl.sv
// rtl/victim_buffer_ctrl.sv - 8-slot victim buffer controller with lookup, insert and LRU pulses
// Define VICTIM_WB_EN to track dirty bits and write back displaced dirty entries.
module victim_buffer_ctrl
  import victim_buffer_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 lk_valid_i,
  output logic                 lk_ready_o,
  input  logic [TAG_W-1:0]     lk_tag_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [DATA_W-1:0]    rsp_data_o,
  input  logic                 ins_valid_i,
  output logic                 ins_ready_o,
  input  logic [TAG_W-1:0]     ins_tag_i,
  input  logic [DATA_W-1:0]    ins_data_i,
  input  logic                 ins_dirty_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [TAG_W-1:0]     wb_tag_o,
  output logic [DATA_W-1:0]    wb_data_o,
  output logic [NUM_SLOTS-1:0] lru_update_o,
  output logic                 add_cache_o,
  input  logic [NUM_SLOTS-1:0] lru_number_i
);

  vb_state_e                state_q;
  vb_slot_t [NUM_SLOTS-1:0] slots_q;
  logic                     rsp_valid_q;
  logic                     rsp_hit_q;
  logic [DATA_W-1:0]        rsp_data_q;
  logic [NUM_SLOTS-1:0]     lru_update_q;
  logic                     add_cache_q;

  logic                     idle;
  logic                     lk_fire;
  logic                     ins_fire;
  logic [TAG_W-1:0]         match_tag;
  logic [NUM_SLOTS-1:0]     hit_vec;
  logic [NUM_SLOTS-1:0]     free_vec;
  logic                     use_lru;
  logic [NUM_SLOTS-1:0]     victim_vec;
  logic [DATA_W-1:0]        hit_data;
  logic                     ins_dirty_eff;
  logic                     need_wb;

  // Readiness is withheld while reset is high so nothing is accepted then.
  assign idle        = (state_q == ST_IDLE) && !reset_i;
  assign lk_ready_o  = idle;
  assign ins_ready_o = idle && !lk_valid_i;
  assign lk_fire     = lk_valid_i && lk_ready_o;
  assign ins_fire    = ins_valid_i && ins_ready_o;
  assign match_tag   = lk_valid_i ? lk_tag_i : ins_tag_i;

  victim_tag_match u_match (
    .tag_i   (match_tag),
    .slots_i (slots_q),
    .hit_o   (hit_vec),
    .free_o  (free_vec)
  );

  assign use_lru    = !(|hit_vec) && !(|free_vec);
  assign victim_vec = (|hit_vec) ? hit_vec : ((|free_vec) ? free_vec : lru_number_i);

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_vec[i]) hit_data = hit_data | slots_q[i].data;
    end
  end

`ifdef VICTIM_WB_EN
  logic              wb_valid_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [TAG_W-1:0]  disp_tag;
  logic [DATA_W-1:0] disp_data;
  logic              disp_dirty;

  always_comb begin
    disp_tag   = '0;
    disp_data  = '0;
    disp_dirty = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (lru_number_i[i]) begin
        disp_tag   = disp_tag | slots_q[i].tag;
        disp_data  = disp_data | slots_q[i].data;
        disp_dirty = disp_dirty | (slots_q[i].valid & slots_q[i].dirty);
      end
    end
  end

  assign ins_dirty_eff = ins_dirty_i;
  assign need_wb       = use_lru && disp_dirty;
  assign wb_valid_o    = wb_valid_q;
  assign wb_tag_o      = wb_tag_q;
  assign wb_data_o     = wb_data_q;
`else
  logic unused_ok;
  assign unused_ok     = ^{wb_ready_i, ins_dirty_i};
  assign ins_dirty_eff = 1'b0;
  assign need_wb       = 1'b0;
  assign wb_valid_o    = 1'b0;
  assign wb_tag_o      = '0;
  assign wb_data_o     = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_data_q   <= '0;
      lru_update_q <= '0;
      add_cache_q  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i].valid <= 1'b0;
        slots_q[i].dirty <= 1'b0;
      end
`ifdef VICTIM_WB_EN
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
`endif
    end else begin
      lru_update_q <= '0;
      add_cache_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lk_fire) begin
            rsp_valid_q  <= 1'b1;
            rsp_hit_q    <= |hit_vec;
            rsp_data_q   <= hit_data;
            lru_update_q <= hit_vec;
            state_q      <= ST_RESP;
          end else if (ins_fire) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (victim_vec[i]) begin
                slots_q[i].valid <= 1'b1;
                slots_q[i].tag   <= ins_tag_i;
                slots_q[i].data  <= ins_data_i;
                // Same-tag overwrite keeps an existing dirty bit.
                slots_q[i].dirty <= ((|hit_vec) & slots_q[i].dirty) | ins_dirty_eff;
              end
            end
            lru_update_q <= use_lru ? '0 : victim_vec;
            add_cache_q  <= use_lru;
`ifdef VICTIM_WB_EN
            if (need_wb) begin
              wb_valid_q <= 1'b1;
              wb_tag_q   <= disp_tag;
              wb_data_q  <= disp_data;
            end
`endif
            state_q <= need_wb ? ST_WB : ST_SETTLE;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= rsp_hit_q ? ST_SETTLE : ST_IDLE;
          end
        end
        ST_WB: begin
`ifdef VICTIM_WB_EN
          if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            state_q    <= ST_SETTLE;
          end
`else
          state_q <= ST_SETTLE;
`endif
        end
        ST_SETTLE: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_data_o   = rsp_data_q;
  assign lru_update_o = lru_update_q;
  assign add_cache_o  = add_cache_q;

endmodule

// File: tb/tb_victim_buffer_ctrl.sv
// tb/tb_victim_buffer_ctrl.sv - self-checking bench for victim_buffer_ctrl (VICTIM_WB_EN optional)
module tb_victim_buffer_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        lk_valid_i;
  logic        lk_ready_o;
  logic [25:0] lk_tag_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_hit_o;
  logic [31:0] rsp_data_o;
  logic        ins_valid_i;
  logic        ins_ready_o;
  logic [25:0] ins_tag_i;
  logic [31:0] ins_data_i;
  logic        ins_dirty_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [25:0] wb_tag_o;
  logic [31:0] wb_data_o;
  logic [7:0]  lru_update_o;
  logic        add_cache_o;
  logic [7:0]  lru_number_i;

  victim_buffer_ctrl dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .lk_valid_i   (lk_valid_i),
    .lk_ready_o   (lk_ready_o),
    .lk_tag_i     (lk_tag_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_hit_o    (rsp_hit_o),
    .rsp_data_o   (rsp_data_o),
    .ins_valid_i  (ins_valid_i),
    .ins_ready_o  (ins_ready_o),
    .ins_tag_i    (ins_tag_i),
    .ins_data_i   (ins_data_i),
    .ins_dirty_i  (ins_dirty_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_tag_o     (wb_tag_o),
    .wb_data_o    (wb_data_o),
    .lru_update_o (lru_update_o),
    .add_cache_o  (add_cache_o),
    .lru_number_i (lru_number_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_ins;
    logic [25:0] tag;
    logic [31:0] data;
    bit          dirty;
    logic [7:0]  lru;
    bit          exp_hit;
    logic [31:0] exp_data;
    logic [7:0]  exp_upd;
    bit          exp_add;
  } vec_t;

  typedef struct {
    bit          hit;
    logic [31:0] data;
    logic [7:0]  upd;
    bit          add;
  } exp_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit is_ins, input logic [25:0] tag, input logic [31:0] data,
                              input bit dirty, input logic [7:0] lru, input bit eh,
                              input logic [31:0] ed, input logic [7:0] eu, input bit ea);
    vec_t v;
    v.is_ins = is_ins; v.tag = tag; v.data = data; v.dirty = dirty; v.lru = lru;
    v.exp_hit = eh; v.exp_data = ed; v.exp_upd = eu; v.exp_add = ea;
    return v;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!lk_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_wait", {63'd0, lk_ready_o}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    wait_idle();
    sb.push_back('{hit: v.exp_hit, data: v.exp_data, upd: v.exp_upd, add: v.exp_add});
    if (v.is_ins) begin
      ins_valid_i = 1'b1; ins_tag_i = v.tag; ins_data_i = v.data;
      ins_dirty_i = v.dirty; lru_number_i = v.lru;
    end else begin
      lk_valid_i = 1'b1; lk_tag_i = v.tag;
    end
    @(negedge clk_i);
    ins_valid_i = 1'b0;
    lk_valid_i  = 1'b0;
    e = sb.pop_front();
    if (v.is_ins) begin
      chk("ins_upd", {56'd0, lru_update_o}, {56'd0, e.upd});
      chk("ins_add", {63'd0, add_cache_o}, {63'd0, e.add});
      chk("ins_busy", {63'd0, ins_ready_o}, 64'd0);
      @(negedge clk_i);
      chk("ins_pulse_end", {55'd0, add_cache_o, lru_update_o}, 64'd0);
      chk("ins_settled", {63'd0, ins_ready_o}, 64'd1);
    end else begin
      chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("rsp_hit", {63'd0, rsp_hit_o}, {63'd0, e.hit});
      chk("rsp_data", {32'd0, rsp_data_o}, {32'd0, e.data});
      chk("lk_upd", {56'd0, lru_update_o}, {56'd0, e.upd});
      @(negedge clk_i);
      chk("lk_pulse_end", {55'd0, add_cache_o, lru_update_o}, 64'd0);
      chk("rsp_done", {63'd0, rsp_valid_o}, 64'd0);
      chk("lk_settle", {63'd0, lk_ready_o}, {63'd0, !e.hit});
    end
  endtask

  initial begin
    int pulses;
    int wb_cycles;
    int n;
    bit seen;

    vecs[0]  = mk(1, 26'h10, 32'hA0000010, 0, 8'h01, 0, 32'h0, 8'h01, 0);
    vecs[1]  = mk(0, 26'h10, 32'h0, 0, 8'h01, 1, 32'hA0000010, 8'h01, 0);
    vecs[2]  = mk(0, 26'h11, 32'h0, 0, 8'h01, 0, 32'h0, 8'h00, 0);
    for (int i = 0; i < 7; i++)
      vecs[3+i] = mk(1, 26'h11 + 26'(i), 32'hA0000011 + 32'(i), 0, 8'h01, 0, 32'h0, 8'h02 << i, 0);
    vecs[10] = mk(1, 26'h10, 32'hB0000010, 0, 8'h01, 0, 32'h0, 8'h01, 0);
    vecs[11] = mk(0, 26'h10, 32'h0, 0, 8'h01, 1, 32'hB0000010, 8'h01, 0);
    vecs[12] = mk(1, 26'h20, 32'hC0000020, 0, 8'h01, 0, 32'h0, 8'h00, 1);
    vecs[13] = mk(0, 26'h10, 32'h0, 0, 8'h01, 0, 32'h0, 8'h00, 0);
    vecs[14] = mk(0, 26'h20, 32'h0, 0, 8'h01, 1, 32'hC0000020, 8'h01, 0);
    vecs[15] = mk(1, 26'h21, 32'hC0000021, 0, 8'h08, 0, 32'h0, 8'h00, 1);
    vecs[16] = mk(0, 26'h13, 32'h0, 0, 8'h08, 0, 32'h0, 8'h00, 0);
    vecs[17] = mk(0, 26'h21, 32'h0, 0, 8'h08, 1, 32'hC0000021, 8'h08, 0);
    vecs[18] = mk(0, 26'h17, 32'h0, 0, 8'h08, 1, 32'hA0000017, 8'h80, 0);

    reset_i = 1'b1; lk_valid_i = 1'b0; lk_tag_i = '0; rsp_ready_i = 1'b1;
    ins_valid_i = 1'b0; ins_tag_i = '0; ins_data_i = '0; ins_dirty_i = 1'b0;
    wb_ready_i = 1'b1; lru_number_i = 8'h01;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {62'd0, lk_ready_o, ins_ready_o}, 64'd0);
    chk("rst_outs", {53'd0, rsp_valid_o, wb_valid_o, add_cache_o, lru_update_o}, 64'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", {62'd0, lk_ready_o, ins_ready_o}, 64'd3);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Lookup held in RESP by a stalled consumer.
    wait_idle();
    rsp_ready_i = 1'b0; lk_valid_i = 1'b1; lk_tag_i = 26'h16;
    @(negedge clk_i);
    lk_valid_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rsp_ready_i = 1'b1;
      if (lru_update_o != 8'h00) begin
        pulses++;
        chk("stall_upd", {56'd0, lru_update_o}, 64'h40);
      end
      chk("stall_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("stall_hit", {63'd0, rsp_hit_o}, 64'd1);
      chk("stall_data", {32'd0, rsp_data_o}, 64'hA0000016);
      @(negedge clk_i);
    end
    chk("stall_released", {63'd0, rsp_valid_o}, 64'd0);
    chk("stall_pulses", 64'(pulses), 64'd1);

    // Simultaneous lookup and insert: lookup wins, insert follows.
    wait_idle();
    lk_valid_i = 1'b1; lk_tag_i = 26'h21;
    ins_valid_i = 1'b1; ins_tag_i = 26'h30; ins_data_i = 32'hD0000030; ins_dirty_i = 1'b0;
    lru_number_i = 8'h02;
    #1;
    chk("both_ins_ready", {63'd0, ins_ready_o}, 64'd0);
    chk("both_lk_ready", {63'd0, lk_ready_o}, 64'd1);
    @(negedge clk_i);
    lk_valid_i = 1'b0;
    chk("both_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("both_rsp_data", {32'd0, rsp_data_o}, 64'hC0000021);
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin
      @(negedge clk_i);
      n++;
      if (add_cache_o) seen = 1'b1;
    end
    ins_valid_i = 1'b0;
    chk("both_ins_done", {63'd0, seen}, 64'd1);
    chk("both_ins_after", 64'(n), 64'd3);
    run_vec(mk(0, 26'h11, 32'h0, 0, 8'h02, 0, 32'h0, 8'h00, 0));
    run_vec(mk(0, 26'h30, 32'h0, 0, 8'h02, 1, 32'hD0000030, 8'h02, 0));

    // Displacing a dirty entry.
    run_vec(mk(1, 26'h40, 32'hE0000040, 1, 8'h04, 0, 32'h0, 8'h00, 1));
    wait_idle();
    wb_ready_i = 1'b0;
    ins_valid_i = 1'b1; ins_tag_i = 26'h41; ins_data_i = 32'hE0000041; ins_dirty_i = 1'b0;
    lru_number_i = 8'h04;
    @(negedge clk_i);
    ins_valid_i = 1'b0;
    chk("disp_add", {63'd0, add_cache_o}, 64'd1);
`ifdef VICTIM_WB_EN
    wb_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) wb_ready_i = 1'b1;
      if (wb_valid_o) begin
        wb_cycles++;
        chk("wb_tag", {38'd0, wb_tag_o}, 64'h40);
        chk("wb_data", {32'd0, wb_data_o}, 64'hE0000040);
      end
      chk("wb_ins_blocked", {63'd0, ins_ready_o}, 64'd0);
      @(negedge clk_i);
      if (c == 2) wb_ready_i = 1'b1;
    end
    chk("wb_cycles", 64'(wb_cycles), 64'd3);
    chk("wb_after_settle", {63'd0, ins_ready_o}, 64'd1);
`else
    wb_cycles = 0;
    chk("nowb_valid", {63'd0, wb_valid_o}, 64'd0);
    chk("nowb_payload", {6'd0, wb_tag_o, wb_data_o}, 64'd0);
    chk("nowb_settle", {63'd0, ins_ready_o}, 64'd0);
    @(negedge clk_i);
    chk("nowb_idle", {63'd0, ins_ready_o}, 64'd1);
    chk("nowb_valid2", {63'd0, wb_valid_o}, 64'(wb_cycles));
`endif
    wb_ready_i = 1'b1;
    run_vec(mk(0, 26'h40, 32'h0, 0, 8'h04, 0, 32'h0, 8'h00, 0));
    run_vec(mk(0, 26'h41, 32'h0, 0, 8'h04, 1, 32'hE0000041, 8'h04, 0));

    // Reset during RESP abandons the response and empties the buffer.
    wait_idle();
    rsp_ready_i = 1'b0; lk_valid_i = 1'b1; lk_tag_i = 26'h41;
    @(negedge clk_i);
    lk_valid_i = 1'b0;
    chk("rr_valid", {63'd0, rsp_valid_o}, 64'd1);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rr_dropped", {63'd0, rsp_valid_o}, 64'd0);
    chk("rr_ready_low", {62'd0, lk_ready_o, ins_ready_o}, 64'd0);
    chk("rr_pulses", {55'd0, add_cache_o, lru_update_o}, 64'd0);
    reset_i = 1'b0; rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rr_ready_back", {63'd0, lk_ready_o}, 64'd1);
    run_vec(mk(0, 26'h41, 32'h0, 0, 8'h04, 0, 32'h0, 8'h00, 0));
    run_vec(mk(0, 26'h17, 32'h0, 0, 8'h04, 0, 32'h0, 8'h00, 0));
    run_vec(mk(0, 26'h20, 32'h0, 0, 8'h04, 0, 32'h0, 8'h00, 0));

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
